hex_entry_bank: RTL and testbench

Parametrised front-panel hex editor: holds `NREGS` registers of `DIGITS` hex digits each, edited digit-by-digit from five debounced push-buttons with a cursor, per-button auto-repeat and optional carry/borrow between digits. It sits between the board button debouncers and the seven-segment display driver. It supplies the operand registers to the datapath under test and the one-hot blink mask to the display.

---
 rtl/enter_pkg.sv | 45 ++++
 rtl/key_repeat.sv | 75 +++++++
 rtl/hex_entry_bank.sv | 116 +++++++++++
 tb/tb_hex_entry_bank.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/enter_pkg.sv
// Shared definitions for the hex entry bank: button indices, repeat FSM states,
// edit operations and the fixed button priority used for decode and retargeting.
package enter_pkg;

    localparam int NBTN      = 5;
    localparam int BTN_LEFT  = 4;
    localparam int BTN_INC   = 3;
    localparam int BTN_RIGHT = 2;
    localparam int BTN_DEC   = 1;
    localparam int BTN_CLR   = 0;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } rpt_state_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_LEFT,
        OP_RIGHT,
        OP_INC,
        OP_DEC,
        OP_CLR
    } op_t;

    // Priority order: left > right > inc > dec > clear.
    function automatic op_t decode_op(input logic [NBTN-1:0] ev);
        if (ev[BTN_LEFT])  return OP_LEFT;
        if (ev[BTN_RIGHT]) return OP_RIGHT;
        if (ev[BTN_INC])   return OP_INC;
        if (ev[BTN_DEC])   return OP_DEC;
        if (ev[BTN_CLR])   return OP_CLR;
        return OP_NONE;
    endfunction

    function automatic logic [2:0] pick_button(input logic [NBTN-1:0] ev);
        if (ev[BTN_LEFT])  return 3'(BTN_LEFT);
        if (ev[BTN_RIGHT]) return 3'(BTN_RIGHT);
        if (ev[BTN_INC])   return 3'(BTN_INC);
        if (ev[BTN_DEC])   return 3'(BTN_DEC);
        return 3'(BTN_CLR);
    endfunction

endpackage

// File: rtl/key_repeat.sv
// Turns five debounced button levels into single-cycle events: one per rising
// edge, plus auto-repeat for the most recently pressed button while it is held.
module key_repeat
    import enter_pkg::*;
#(
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] i_levels,
    input  logic            i_en,
    output logic [NBTN-1:0] o_events
);

    localparam int MAX_CNT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] LOAD_DELAY  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] LOAD_PERIOD = CNT_W'(REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    rpt_state_t       r_state;
    logic [2:0]       r_btn;
    logic [CNT_W-1:0] r_cnt;
    logic [NBTN-1:0]  r_prev;
    logic [NBTN-1:0]  r_rep;

    logic [NBTN-1:0]  w_rise;
    logic             w_held;

    assign w_rise   = i_levels & ~r_prev;
    assign w_held   = i_levels[r_btn];
    // The repeat pulse is prepared a cycle early; a release in that cycle still cancels it.
    assign o_events = i_en ? (w_rise | (r_rep & i_levels)) : '0;

    // NOTE: every register in a clocked block uses <= so all state updates see
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_btn   <= '0;
            r_cnt   <= '0;
            // Treat every button as already held so one held through reset needs a fresh press.
            r_prev  <= '1;
            r_rep   <= '0;
        end else begin
            r_prev <= i_levels;
            r_rep  <= '0;
            if (!i_en) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else if (|w_rise) begin
                r_state <= DELAY;
                r_btn   <= pick_button(w_rise);
                r_cnt   <= LOAD_DELAY;
            end else if (r_state != IDLE && !w_held) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    DELAY, REPEAT: begin
                        if (r_cnt == CNT_ONE) begin
                            r_rep   <= NBTN'(1) << r_btn;
                            r_state <= REPEAT;
                            r_cnt   <= LOAD_PERIOD;
                        end else begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/hex_entry_bank.sv
// Front-panel hex editor: a bank of NREGS registers edited nibble by nibble
// from five buttons, with cursor, optional carry, bulk load and blink mask.
module hex_entry_bank
    import enter_pkg::*;
#(
    parameter int                        DIGITS        = 8,
    parameter int                        NREGS         = 2,
    parameter logic [NREGS*4*DIGITS-1:0] INIT          = 64'hD7BDFBD9_557EF7E0,
    parameter bit                        CARRY         = 1'b0,
    parameter int                        REPEAT_DELAY  = 25_000_000,
    parameter int                        REPEAT_PERIOD = 5_000_000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NBTN-1:0]             BTN_OK,
    input  logic                        en,
    input  logic [2:0]                  sel,
    input  logic                        load,
    input  logic [4*DIGITS-1:0]         load_data,
    output logic [NREGS*4*DIGITS-1:0]   values,
    output logic [$clog2(DIGITS)-1:0]   cursor,
    output logic [DIGITS-1:0]           blink,
    output logic                        changed
);

    localparam int RW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS);
    localparam int SW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [CW-1:0] CUR_MAX = CW'(DIGITS - 1);

    logic [RW-1:0]   r_regs [NREGS];
    logic [CW-1:0]   r_cursor;
    logic            r_changed;

    logic [NBTN-1:0] w_events;
    op_t             w_op;
    logic            w_sel_ok;
    logic [SW-1:0]   w_sel_idx;
    logic [RW-1:0]   w_cur;
    logic [RW-1:0]   w_step;
    logic [RW-1:0]   w_next;
    logic [3:0]      w_nib;
    logic            w_write;

    key_repeat #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_key_repeat (
        .clk      (clk),
        .rst      (rst),
        .i_levels (BTN_OK),
        .i_en     (en),
        .o_events (w_events)
    );

    assign w_op      = decode_op(w_events);
    assign w_sel_ok  = (int'(sel) < NREGS);
    assign w_sel_idx = w_sel_ok ? sel[SW-1:0] : '0;
    assign w_cur     = r_regs[w_sel_idx];
    assign w_nib     = w_cur[4*r_cursor +: 4];
    assign w_step    = RW'(1) << (4 * r_cursor);

    // NOTE: w_next gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next = w_cur;
        case (w_op)
            OP_INC: begin
                if (CARRY) w_next = w_cur + w_step;
                else       w_next[4*r_cursor +: 4] = w_nib + 4'd1;
            end
            OP_DEC: begin
                if (CARRY) w_next = w_cur - w_step;
                else       w_next[4*r_cursor +: 4] = w_nib - 4'd1;
            end
            OP_CLR:  w_next[4*r_cursor +: 4] = 4'd0;
            default: ;
        endcase
    end

    // A load masks every button action, including cursor moves.
    assign w_write = w_sel_ok && (load || (w_op inside {OP_INC, OP_DEC, OP_CLR}));

    // NOTE: the bank is reset element by element because it must come out of
    // reset holding INIT; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                r_regs[r] <= INIT[r*RW +: RW];
            end
            r_cursor  <= CUR_MAX;
            r_changed <= 1'b0;
        end else begin
            r_changed <= w_write;
            if (w_write) begin
                r_regs[w_sel_idx] <= load ? load_data : w_next;
            end
            if (!load) begin
                case (w_op)
                    OP_LEFT:  r_cursor <= (r_cursor == CUR_MAX) ? '0 : r_cursor + 1'b1;
                    OP_RIGHT: r_cursor <= (r_cursor == '0) ? CUR_MAX : r_cursor - 1'b1;
                    default:  ;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_pack
        assign values[g*RW +: RW] = r_regs[g];
    end

    assign cursor  = r_cursor;
    assign blink   = en ? (DIGITS'(1) << r_cursor) : '0;
    assign changed = r_changed;

endmodule

// File: tb/tb_hex_entry_bank.sv
// Directed bench for hex_entry_bank: a vector table for single presses on the
// default bank, plus sequences for repeat timing, carry and reset mid-repeat.
module tb_hex_entry_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  btn_a, btn_b;
    logic        en;
    logic [2:0]  sel;
    logic        load_a, load_b;
    logic [31:0] ld_a;
    logic [15:0] ld_b;

    logic [63:0] va;
    logic [2:0]  cur_a;
    logic [7:0]  blink_a;
    logic        chg_a;
    logic [31:0] vc, vn;
    logic [1:0]  cur_c, cur_n;
    logic [3:0]  blink_c, blink_n;
    logic        chg_c, chg_n;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [63:0] INIT_A = 64'hD7BDFBD9_557EF7E0;
    localparam logic [31:0] INIT_B = 32'h1234_0FFF;

    always #5 clk = ~clk;

    hex_entry_bank #(
        .DIGITS(8), .NREGS(2), .INIT(INIT_A), .CARRY(1'b0),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) u_a (
        .clk(clk), .rst(rst), .BTN_OK(btn_a), .en(en), .sel(sel),
        .load(load_a), .load_data(ld_a), .values(va), .cursor(cur_a),
        .blink(blink_a), .changed(chg_a)
    );

    hex_entry_bank #(
        .DIGITS(4), .NREGS(2), .INIT(INIT_B), .CARRY(1'b1),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) u_c (
        .clk(clk), .rst(rst), .BTN_OK(btn_b), .en(en), .sel(sel),
        .load(load_b), .load_data(ld_b), .values(vc), .cursor(cur_c),
        .blink(blink_c), .changed(chg_c)
    );

    hex_entry_bank #(
        .DIGITS(4), .NREGS(2), .INIT(INIT_B), .CARRY(1'b0),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) u_n (
        .clk(clk), .rst(rst), .BTN_OK(btn_b), .en(en), .sel(sel),
        .load(load_b), .load_data(ld_b), .values(vn), .cursor(cur_n),
        .blink(blink_n), .changed(chg_n)
    );

    typedef struct {
        logic [4:0]  btn;
        logic        en;
        logic [2:0]  sel;
        logic        load;
        logic [31:0] ld;
        logic [31:0] e_r0;
        logic [31:0] e_r1;
        logic [2:0]  e_cur;
        logic [7:0]  e_blink;
        logic        e_chg;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(input logic [4:0] btn, input logic e, input logic [2:0] s,
                                input logic l, input logic [31:0] d, input logic [31:0] r0,
                                input logic [31:0] r1, input logic [2:0] c,
                                input logic [7:0] b, input logic ch);
        vec_t v;
        v.btn = btn; v.en = e; v.sel = s; v.load = l; v.ld = d;
        v.e_r0 = r0; v.e_r1 = r1; v.e_cur = c; v.e_blink = b; v.e_chg = ch;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        btn_a = v.btn; en = v.en; sel = v.sel; load_a = v.load; ld_a = v.ld;
        @(posedge clk); #1;
        check($sformatf("v%0d reg0", idx),    va[31:0],  v.e_r0);
        check($sformatf("v%0d reg1", idx),    va[63:32], v.e_r1);
        check($sformatf("v%0d cursor", idx),  cur_a,     v.e_cur);
        check($sformatf("v%0d blink", idx),   blink_a,   v.e_blink);
        check($sformatf("v%0d changed", idx), chg_a,     v.e_chg);
        @(negedge clk);
        btn_a = '0; load_a = 1'b0;
        @(posedge clk); #1;
        check($sformatf("v%0d changed idle", idx), chg_a, 1'b0);
    endtask

    task automatic pulse_b(input logic [4:0] mask);
        @(negedge clk);
        btn_b = mask;
        @(negedge clk);
        btn_b = '0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [19:0] obs;
        int          cnt;

        rst = 1'b1; btn_a = '0; btn_b = '0; en = 1'b1; sel = '0;
        load_a = 1'b0; load_b = 1'b0; ld_a = '0; ld_b = '0;

        vecs[0]  = mk(5'b10000, 1, 0, 0, 32'h0,        32'h557EF7E0, 32'hD7BDFBD9, 0, 8'h01, 0);
        vecs[1]  = mk(5'b01000, 1, 0, 0, 32'h0,        32'h557EF7E1, 32'hD7BDFBD9, 0, 8'h01, 1);
        vecs[2]  = mk(5'b00010, 1, 0, 0, 32'h0,        32'h557EF7E0, 32'hD7BDFBD9, 0, 8'h01, 1);
        vecs[3]  = mk(5'b00010, 1, 0, 0, 32'h0,        32'h557EF7EF, 32'hD7BDFBD9, 0, 8'h01, 1);
        vecs[4]  = mk(5'b00100, 1, 0, 0, 32'h0,        32'h557EF7EF, 32'hD7BDFBD9, 7, 8'h80, 0);
        vecs[5]  = mk(5'b01000, 1, 0, 0, 32'h0,        32'h657EF7EF, 32'hD7BDFBD9, 7, 8'h80, 1);
        vecs[6]  = mk(5'b00001, 1, 0, 0, 32'h0,        32'h057EF7EF, 32'hD7BDFBD9, 7, 8'h80, 1);
        vecs[7]  = mk(5'b11000, 1, 0, 0, 32'h0,        32'h057EF7EF, 32'hD7BDFBD9, 0, 8'h01, 0);
        vecs[8]  = mk(5'b01011, 1, 0, 0, 32'h0,        32'h057EF7E0, 32'hD7BDFBD9, 0, 8'h01, 1);
        vecs[9]  = mk(5'b00010, 1, 1, 0, 32'h0,        32'h057EF7E0, 32'hD7BDFBD8, 0, 8'h01, 1);
        vecs[10] = mk(5'b01000, 1, 1, 1, 32'h12345678, 32'h057EF7E0, 32'h12345678, 0, 8'h01, 1);
        vecs[11] = mk(5'b01000, 1, 5, 0, 32'h0,        32'h057EF7E0, 32'h12345678, 0, 8'h01, 0);
        vecs[12] = mk(5'b10000, 1, 5, 0, 32'h0,        32'h057EF7E0, 32'h12345678, 1, 8'h02, 0);
        vecs[13] = mk(5'b01000, 0, 0, 0, 32'h0,        32'h057EF7E0, 32'h12345678, 1, 8'h00, 0);
        vecs[14] = mk(5'b00000, 0, 0, 1, 32'hAAAA5555, 32'hAAAA5555, 32'h12345678, 1, 8'h00, 1);
        vecs[15] = mk(5'b00001, 1, 0, 0, 32'h0,        32'hAAAA5505, 32'h12345678, 1, 8'h02, 1);
        vecs[16] = mk(5'b00000, 1, 0, 1, 32'hAAAA5505, 32'hAAAA5505, 32'h12345678, 1, 8'h02, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset values a", va,      INIT_A);
        check("reset cursor a", cur_a,   3'd7);
        check("reset blink a",  blink_a, 8'h80);
        check("reset changed",  chg_a,   1'b0);
        check("reset values c", vc,      INIT_B);
        check("reset cursor c", cur_c,   2'd3);

        for (int i = 0; i < 17; i++) apply(i, vecs[i]);

        // Auto-repeat: clear reg0, then hold decrement for 20 cycles at cursor 1.
        @(negedge clk);
        sel = 3'd0; load_a = 1'b1; ld_a = 32'h0;
        @(negedge clk);
        load_a = 1'b0; btn_a = 5'b00010;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            obs[i] = chg_a;
        end
        @(negedge clk);
        btn_a = '0;
        check("repeat event pattern", obs, 20'h92401);
        repeat (6) @(posedge clk);
        #1;
        check("repeat digit -5", va[31:0], 32'h000000B0);

        // Carry vs. no-carry on a 4-digit register holding 0FFF.
        pulse_b(5'b10000);
        check("carry cursor",  cur_c,     2'd0);
        check("carry blink",   blink_c,   4'b0001);
        pulse_b(5'b01000);
        check("carry inc",     vc[15:0],  16'h1000);
        check("nocarry inc",   vn[15:0],  16'h0FF0);
        check("carry reg1",    vc[31:16], 16'h1234);
        pulse_b(5'b00010);
        check("carry dec",     vc[15:0],  16'h0FFF);
        check("nocarry dec",   vn[15:0],  16'h0FFF);
        @(negedge clk);
        load_b = 1'b1; ld_b = 16'hFFFF;
        @(negedge clk);
        load_b = 1'b0;
        pulse_b(5'b01000);
        check("carry wrap",    vc[15:0],  16'h0000);
        check("nocarry wrap",  vn[15:0],  16'hFFF0);
        pulse_b(5'b00100);
        check("carry cursor wrap", cur_c, 2'd3);
        pulse_b(5'b01000);
        check("carry inc top", vc[15:0],  16'h1000);
        check("nocarry inc top", vn[15:0], 16'h0FF0);

        // Reset in the middle of a held increment.
        @(negedge clk);
        sel = 3'd0; btn_a = 5'b01000;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async reset values", va,    INIT_A);
        check("async reset cursor", cur_a, 3'd7);
        check("async reset changed", chg_a, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (chg_a) cnt++;
        end
        check("no events after reset", cnt, 0);
        check("values after reset hold", va, INIT_A);
        @(negedge clk);
        btn_a = '0;
        @(negedge clk);
        btn_a = 5'b01000;
        @(posedge clk); #1;
        check("fresh press value",   va[31:0], 32'h657EF7E0);
        check("fresh press changed", chg_a,    1'b1);
        @(negedge clk);
        btn_a = '0;
        @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
